rip_bp_table_ctrl: RTL and testbench

//  Sequences the single-port branch-predictor table SRAM: 2**INDEX_W entries of bp_weight_t.

---
 rtl/rip_bp_table_ctrl_pkg.sv | 25 ++
 rtl/rip_bp_table_ctrl_upd_fifo.sv | 77 +++++++
 rtl/rip_bp_table_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rip_bp_table_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rip_bp_table_ctrl_pkg.sv
// Shared constants and types for the branch-predictor table controller.
// Holds the table geometry, the update FIFO sizing and the controller state encoding.
package rip_branch_predictor_const;

    localparam int TABLE_DEPTH       = 4;
    localparam int TABLE_WIDTH       = 2;
    localparam int BP_UPD_FIFO_DEPTH = 4;
    localparam int BP_STARVE_LIMIT   = 8;

    typedef logic [TABLE_DEPTH-1:0] bp_index_t;
    typedef logic [TABLE_WIDTH-1:0] bp_weight_t;

    localparam bp_weight_t WEAKLY_UNTAKEN = 2'b01;

    typedef struct packed {
        bp_index_t  index;
        bp_weight_t data;
    } bp_upd_req_t;

    typedef enum logic {
        BP_CTRL_INIT = 1'b0,
        BP_CTRL_RUN  = 1'b1
    } bp_ctrl_state_t;

endpackage

// File: rtl/rip_bp_table_ctrl_upd_fifo.sv
// Update FIFO for the predictor table controller.
// Every slot and its valid bit are visible so lookups can be bypassed from queued updates.
module rip_bp_upd_fifo import rip_branch_predictor_const::*; #(
    parameter int INDEX_W = TABLE_DEPTH,
    parameter int DATA_W  = TABLE_WIDTH,
    parameter int DEPTH   = BP_UPD_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [INDEX_W-1:0] push_index_i,
    input  logic [DATA_W-1:0]  push_data_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [INDEX_W-1:0] head_index_o,
    output logic [DATA_W-1:0]  head_data_o,
    output logic [PTR_W-1:0]   rd_ptr_o,
    output logic [DEPTH-1:0]   valid_o,
    output logic [INDEX_W-1:0] ent_index_o [DEPTH],
    output logic [DATA_W-1:0]  ent_data_o  [DEPTH]
);

    logic [DEPTH-1:0]   valid_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [INDEX_W-1:0] index_r [DEPTH];
    logic [DATA_W-1:0]  data_r  [DEPTH];

    // Occupancy is tracked per slot, so full/empty fall out of the slot under each pointer.
    assign full_o       = valid_r[wr_ptr_r];
    assign empty_o      = ~valid_r[rd_ptr_r];
    assign head_index_o = index_r[rd_ptr_r];
    assign head_data_o  = data_r[rd_ptr_r];
    assign rd_ptr_o     = rd_ptr_r;
    assign valid_o      = valid_r;
    assign ent_index_o  = index_r;
    assign ent_data_o   = data_r;

    // Pointer and valid-mask update; flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush_i) begin
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_i) begin
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_i) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Entry payload storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                index_r[i] <= '0;
                data_r[i]  <= '0;
            end
        end else if (push_i && !flush_i) begin
            index_r[wr_ptr_r] <= push_index_i;
            data_r[wr_ptr_r]  <= push_data_i;
        end
    end

endmodule

// File: rtl/rip_bp_table_ctrl.sv
// Sequencer for the single-port branch-predictor table SRAM: clear, lookup/update
// arbitration with starvation guard, and bypass of queued updates into lookup responses.
module rip_bp_table_ctrl import rip_branch_predictor_const::*; #(
    parameter int INDEX_W      = TABLE_DEPTH,
    parameter int DATA_W       = TABLE_WIDTH,
    parameter int FIFO_DEPTH   = BP_UPD_FIFO_DEPTH,
    parameter int STARVE_LIMIT = BP_STARVE_LIMIT,
    parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               init_req_i,
    output logic               init_busy_o,
    input  logic               lk_valid_i,
    output logic               lk_ready_o,
    input  logic [INDEX_W-1:0] lk_index_i,
    output logic               rsp_valid_o,
    output logic [DATA_W-1:0]  rsp_data_o,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [INDEX_W-1:0] up_index_i,
    input  logic [DATA_W-1:0]  up_data_i,
    output logic               mem_en_o,
    output logic               mem_we_o,
    output logic [INDEX_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic [DATA_W-1:0]  mem_rdata_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    bp_ctrl_state_t     state_r;
    logic               active_r;
    logic [INDEX_W-1:0] init_cnt_r;
    logic [SC_W-1:0]    starve_cnt_r;
    logic               rsp_valid_r;
    logic               byp_hit_r;
    logic [DATA_W-1:0]  byp_data_r;

    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [INDEX_W-1:0] fifo_head_index_s;
    logic [DATA_W-1:0]  fifo_head_data_s;
    logic [PTR_W-1:0]   fifo_rd_ptr_s;
    logic [FIFO_DEPTH-1:0] fifo_valid_s;
    logic [INDEX_W-1:0] fifo_index_s [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data_s  [FIFO_DEPTH];

    logic               in_run_s;
    logic               init_wr_s;
    logic               upd_forced_s;
    logic               upd_go_s;
    logic               lk_go_s;
    logic               push_s;
    logic               flush_s;
    logic               byp_hit_s;
    logic [DATA_W-1:0]  byp_data_s;
    logic [PTR_W-1:0]   slot_s;

    // active_r keeps the SRAM port quiet while reset is held and for the release cycle.
    assign in_run_s     = active_r && (state_r == BP_CTRL_RUN);
    assign init_wr_s    = active_r && (state_r == BP_CTRL_INIT);
    assign upd_forced_s = !fifo_empty_s && (fifo_full_s || (starve_cnt_r == SC_W'(STARVE_LIMIT)));
    assign lk_ready_o   = in_run_s && !upd_forced_s;
    assign up_ready_o   = in_run_s && !fifo_full_s;
    assign upd_go_s     = in_run_s && !init_req_i && !fifo_empty_s && (upd_forced_s || !lk_valid_i);
    assign lk_go_s      = lk_valid_i && lk_ready_o;
    assign push_s       = up_valid_i && up_ready_o;
    assign flush_s      = in_run_s && init_req_i;
    assign init_busy_o  = (state_r == BP_CTRL_INIT);
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_data_o   = byp_hit_r ? byp_data_r : mem_rdata_i;

    rip_bp_upd_fifo #(
        .INDEX_W (INDEX_W),
        .DATA_W  (DATA_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_upd_fifo (
        .clk          (clk),
        .rstn         (rstn),
        .flush_i      (flush_s),
        .push_i       (push_s),
        .push_index_i (up_index_i),
        .push_data_i  (up_data_i),
        .pop_i        (upd_go_s),
        .full_o       (fifo_full_s),
        .empty_o      (fifo_empty_s),
        .head_index_o (fifo_head_index_s),
        .head_data_o  (fifo_head_data_s),
        .rd_ptr_o     (fifo_rd_ptr_s),
        .valid_o      (fifo_valid_s),
        .ent_index_o  (fifo_index_s),
        .ent_data_o   (fifo_data_s)
    );

    // SRAM port is driven in the access cycle so read data lands in the response cycle.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (init_wr_s) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = init_cnt_r;
            mem_wdata_o = INIT_VALUE;
        end else if (upd_go_s) begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = fifo_head_index_s;
            mem_wdata_o = fifo_head_data_s;
        end else if (lk_go_s) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = lk_index_i;
        end else begin
            mem_en_o    = 1'b0;
        end
    end

    // Walk queued entries oldest to youngest so the last match is the newest value.
    always_comb begin
        byp_hit_s  = 1'b0;
        byp_data_s = '0;
        slot_s     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_s = fifo_rd_ptr_s + PTR_W'(i);
            if (fifo_valid_s[slot_s] && (fifo_index_s[slot_s] == lk_index_i)) begin
                byp_hit_s  = 1'b1;
                byp_data_s = fifo_data_s[slot_s];
            end else begin
                byp_hit_s  = byp_hit_s;
            end
        end
    end

    // Controller FSM, starvation counter and response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= BP_CTRL_INIT;
            active_r     <= 1'b0;
            init_cnt_r   <= '0;
            starve_cnt_r <= '0;
            rsp_valid_r  <= 1'b0;
            byp_hit_r    <= 1'b0;
            byp_data_r   <= '0;
        end else begin
            active_r    <= 1'b1;
            rsp_valid_r <= lk_go_s;
            byp_hit_r   <= lk_go_s && byp_hit_s;
            byp_data_r  <= lk_go_s ? byp_data_s : '0;
            case (state_r)
                BP_CTRL_INIT: begin
                    if (active_r) begin
                        init_cnt_r <= init_cnt_r + INDEX_W'(1);
                        if (init_cnt_r == {INDEX_W{1'b1}}) begin
                            state_r <= BP_CTRL_RUN;
                        end
                    end
                end
                BP_CTRL_RUN: begin
                    if (init_req_i) begin
                        state_r      <= BP_CTRL_INIT;
                        init_cnt_r   <= '0;
                        starve_cnt_r <= '0;
                    end else if (upd_go_s) begin
                        starve_cnt_r <= '0;
                    end else if (lk_go_s && !fifo_empty_s && (starve_cnt_r != SC_W'(STARVE_LIMIT))) begin
                        starve_cnt_r <= starve_cnt_r + SC_W'(1);
                    end
                end
                default: begin
                    state_r <= BP_CTRL_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rip_bp_table_ctrl.sv
// Directed bench for rip_bp_table_ctrl with a one-cycle-latency SRAM model.
module tb_rip_bp_table_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       init_req_i;
    logic       init_busy_o;
    logic       lk_valid_i;
    logic       lk_ready_o;
    logic [3:0] lk_index_i;
    logic       rsp_valid_o;
    logic [1:0] rsp_data_o;
    logic       up_valid_i;
    logic       up_ready_o;
    logic [3:0] up_index_i;
    logic [1:0] up_data_i;
    logic       mem_en_o;
    logic       mem_we_o;
    logic [3:0] mem_addr_o;
    logic [1:0] mem_wdata_o;
    logic [1:0] mem_rdata_i;

    logic [1:0] sram [16];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rip_bp_table_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .init_req_i  (init_req_i),
        .init_busy_o (init_busy_o),
        .lk_valid_i  (lk_valid_i),
        .lk_ready_o  (lk_ready_o),
        .lk_index_i  (lk_index_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_index_i  (up_index_i),
        .up_data_i   (up_data_i),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // SRAM model: synchronous write, read data one cycle after a read enable.
    always @(posedge clk) begin
        if (mem_en_o && mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
        if (mem_en_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle: inputs change 1 time unit after the edge, checks 1 unit later.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port_bus();
        return 32'({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o});
    endfunction

    function automatic logic [31:0] exp_bus(input logic en, input logic we, input int addr, input logic [1:0] wd);
        logic [3:0] a;
        a = 4'(addr);
        return 32'({en, we, a, wd});
    endfunction

    task automatic wait_first_write(input string tag);
        int n;
        n = 0;
        while (mem_en_o !== 1'b1 && n < 4) begin
            adv();
            #1;
            n++;
        end
        chk(tag, 32'(mem_en_o), 32'(1));
    endtask

    task automatic check_clear(input string tag, input int inject_req_at);
        for (int i = 0; i < 16; i++) begin
            init_req_i = (i == inject_req_at);
            #1;
            chk(tag, port_bus(), exp_bus(1'b1, 1'b1, i, 2'b01));
            adv();
        end
        init_req_i = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; init_req_i = 1'b0; lk_valid_i = 1'b0; lk_index_i = 4'd0;
        up_valid_i = 1'b0; up_index_i = 4'd0; up_data_i = 2'b00;
        adv(); adv();
        #1;
        chk("rst_bus", port_bus(), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        chk("rst_busy", 32'(init_busy_o), 32'(1));
        chk("rst_readies", 32'({lk_ready_o, up_ready_o}), 32'(0));

        // Clear after reset release
        adv();
        rstn = 1'b1;
        #1;
        wait_first_write("first_clear_write");
        chk("init_lk_ready", 32'(lk_ready_o), 32'(0));
        check_clear("clear_after_reset", -1);
        #1;
        chk("run_busy", 32'(init_busy_o), 32'(0));
        chk("run_readies", 32'({lk_ready_o, up_ready_o}), 32'(3));

        // Update on idle bus then lookup from SRAM
        up_valid_i = 1'b1; up_index_i = 4'd3; up_data_i = 2'b11;
        #1;
        chk("enq_no_same_cycle_write", 32'(mem_en_o), 32'(0));
        adv();
        up_valid_i = 1'b0;
        #1;
        chk("idle_update_write", port_bus(), exp_bus(1'b1, 1'b1, 3, 2'b11));
        adv();
        lk_valid_i = 1'b1; lk_index_i = 4'd3;
        #1;
        chk("lookup3_read", port_bus(), exp_bus(1'b1, 1'b0, 3, 2'b00));
        adv();
        lk_valid_i = 1'b0;
        #1;
        chk("lookup3_rsp", 32'({rsp_valid_o, rsp_data_o}), 32'({1'b1, 2'b11}));

        // Youngest bypass under continuous lookups
        adv();
        lk_valid_i = 1'b1; lk_index_i = 4'd0;
        adv();
        up_valid_i = 1'b1; up_index_i = 4'd5; up_data_i = 2'b10;
        adv();
        up_data_i = 2'b11;
        #1;
        chk("second_enq_no_write", 32'(mem_we_o), 32'(0));
        adv();
        up_valid_i = 1'b0; lk_index_i = 4'd5;
        #1;
        chk("lookup5_read", port_bus(), exp_bus(1'b1, 1'b0, 5, 2'b00));
        adv();
        lk_valid_i = 1'b0;
        #1;
        chk("bypass_youngest", 32'({rsp_valid_o, rsp_data_o}), 32'({1'b1, 2'b11}));
        chk("drain5_a", port_bus(), exp_bus(1'b1, 1'b1, 5, 2'b10));
        adv();
        #1;
        chk("drain5_b", port_bus(), exp_bus(1'b1, 1'b1, 5, 2'b11));
        adv();
        #1;
        chk("drained_idle", 32'(mem_en_o), 32'(0));

        // Starvation limit
        adv();
        lk_valid_i = 1'b1; lk_index_i = 4'd0;
        up_valid_i = 1'b1; up_index_i = 4'd7; up_data_i = 2'b10;
        adv();
        up_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("starve_lookup_won", 32'({lk_ready_o, mem_en_o, mem_we_o}), 32'(3'b110));
            adv();
        end
        #1;
        chk("starve_lk_ready", 32'(lk_ready_o), 32'(0));
        chk("starve_forced_write", port_bus(), exp_bus(1'b1, 1'b1, 7, 2'b10));
        adv();
        #1;
        chk("after_forced_lookup", 32'({lk_ready_o, mem_en_o, mem_we_o}), 32'(3'b110));

        // FIFO full forces an update
        adv();
        up_valid_i = 1'b1; up_index_i = 4'd8; up_data_i = 2'b00;
        adv();
        up_index_i = 4'd9; up_data_i = 2'b11;
        adv();
        up_index_i = 4'd10; up_data_i = 2'b10;
        adv();
        up_index_i = 4'd11; up_data_i = 2'b00;
        #1;
        chk("fourth_enq_ready", 32'(up_ready_o), 32'(1));
        adv();
        up_valid_i = 1'b0;
        #1;
        chk("full_readies", 32'({lk_ready_o, up_ready_o}), 32'(0));
        chk("full_forced_write", port_bus(), exp_bus(1'b1, 1'b1, 8, 2'b00));
        adv();
        #1;
        chk("after_full_lookup", 32'({lk_ready_o, up_ready_o, mem_we_o}), 32'(3'b110));
        adv();
        lk_valid_i = 1'b0;
        #1;
        chk("drain9", port_bus(), exp_bus(1'b1, 1'b1, 9, 2'b11));
        adv();
        #1;
        chk("drain10", port_bus(), exp_bus(1'b1, 1'b1, 10, 2'b10));
        adv();
        #1;
        chk("drain11", port_bus(), exp_bus(1'b1, 1'b1, 11, 2'b00));

        // Re-init with queued updates and a lookup in flight
        adv();
        lk_valid_i = 1'b1; lk_index_i = 4'd0;
        up_valid_i = 1'b1; up_index_i = 4'd1; up_data_i = 2'b00;
        adv();
        up_index_i = 4'd2;
        adv();
        up_index_i = 4'd4;
        adv();
        up_valid_i = 1'b0; lk_index_i = 4'd3; init_req_i = 1'b1;
        #1;
        chk("reinit_lookup_read", port_bus(), exp_bus(1'b1, 1'b0, 3, 2'b00));
        adv();
        lk_valid_i = 1'b0; init_req_i = 1'b0;
        #1;
        chk("reinit_rsp", 32'({rsp_valid_o, rsp_data_o}), 32'({1'b1, 2'b11}));
        chk("reinit_busy_readies", 32'({init_busy_o, lk_ready_o, up_ready_o}), 32'(3'b100));
        check_clear("clear_after_req", 5);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("flushed_no_write", 32'({init_busy_o, mem_en_o}), 32'(0));
            adv();
        end

        // Reset in the middle of clearing
        init_req_i = 1'b1;
        adv();
        init_req_i = 1'b0;
        for (int i = 0; i < 7; i++) adv();
        #1;
        chk("mid_clear_addr7", port_bus(), exp_bus(1'b1, 1'b1, 7, 2'b01));
        rstn = 1'b0;
        #1;
        chk("async_rst_bus", port_bus(), 32'(0));
        chk("async_rst_rsp_ready", 32'({rsp_valid_o, lk_ready_o, up_ready_o}), 32'(0));
        adv();
        rstn = 1'b1;
        #1;
        wait_first_write("restart_first_write");
        check_clear("clear_restart", -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
